ex_commit_bjp: RTL
==================

// Module: ex_commit_bjp
// PURPOSE
//  Branch/flush commit stage. Sits directly downstream of the ALU branch-resolve unit.
//  Consumes its commit-side outputs: valid, bjp, mret, dret, fencei, prdt and rslv.
//  Detects mispredicted branches and mret/dret/fence.i, and computes the redirect PC.
//  Holds a registered flush request toward the IFU until acknowledged, stalling commit meanwhile.
//  Keeps saturating branch / mispredict performance counters.
// PARAMETERS
//  PC_SIZE  32  width of all PC/immediate/target datapaths
//  CNT_W    16  width of the performance counters
// PORTS
//  clk              in   1        clock
//  rst_n            in   1        asynchronous active-low reset
//  cmt_i_valid      in   1        commit request from branch-resolve unit
//  cmt_i_ready      out  1        commit accepted this cycle
//  cmt_i_bjp        in   1        instruction is branch or jump
//  cmt_i_mret       in   1        instruction is mret
//  cmt_i_dret       in   1        instruction is dret
//  cmt_i_fencei     in   1        instruction is fence.i
//  cmt_i_prdt       in   1        predicted taken
//  cmt_i_rslv       in   1        resolved taken (always 1 for jumps)
//  cmt_i_rv32       in   1        1: 32-bit instr (len 4), 0: compressed (len 2)
//  cmt_i_pc         in   PC_SIZE  PC of committing instruction
//  cmt_i_imm        in   PC_SIZE  branch offset, sign-extended
//  csr_mepc         in   PC_SIZE  mret target
//  csr_dpc          in   PC_SIZE  dret target
//  flush_req        out  1        redirect request to IFU (registered)
//  flush_ack        in   1        IFU accepts redirect
//  flush_pc         out  PC_SIZE  redirect target (registered, stable while flush_req=1)
//  cmt_o_mispred    out  1        one-cycle strobe: accepted commit is a mispredicted branch
//  bjp_cnt          out  CNT_W    accepted bjp commits, saturating
//  mispred_cnt      out  CNT_W    accepted mispredicts, saturating
// BEHAVIOUR
//  - Clocking: single clock clk. rst_n is async assert, sync deassert.
//    Reset values: state=IDLE, flush_req=0, flush_pc=0, bjp_cnt=0, mispred_cnt=0.
//  - Commit fire: fire = cmt_i_valid & cmt_i_ready. cmt_i_ready = (state==IDLE); no dependence on cmt_i_valid.
//  - Mispredict: mispred = cmt_i_bjp & (cmt_i_prdt ^ cmt_i_rslv).
//    need_flush = mispred | mret | dret | fencei.
//  - Target priority (if multiple flags are set):
//    1. dret   -> csr_dpc
//    2. mret   -> csr_mepc
//    3. fencei -> pc+len
//    4. mispred & rslv  -> pc+imm
//    5. mispred & ~rslv -> pc+len
//    len = rv32 ? 4 : 2. All adds are modulo 2^PC_SIZE; carry is dropped.
//  - FSM IDLE: fire & need_flush -> FLUSH. Next cycle flush_req=1 and flush_pc=target.
//    Fire without need_flush stays IDLE. Back-to-back fires are allowed every cycle.
//  - FSM FLUSH: cmt_i_ready=0, flush_req=1, and flush_pc is held.
//    flush_ack=1 -> IDLE. flush_req=0 next cycle and commit is accepted from that cycle.
//  - flush_ack in IDLE is ignored.
//  - Minimum turnaround: fire at cycle T, req at T+1, ack at T+1, ready at T+2.
//  - cmt_o_mispred = fire & mispred (combinational, same cycle as fire).
//  - Counters:
//    fire & bjp increments bjp_cnt.
//    fire & mispred increments mispred_cnt.
//    Both saturate at 2^CNT_W-1 with no wrap, and they update in the same cycle.
//  - Reset mid-FLUSH: flush_req drops immediately (async) and the pending target is discarded.
//  - Inputs are don't-care when cmt_i_valid=0; no state changes.
// TESTING
//  1. Correct prediction: bjp=1, prdt=1, rslv=1 -> ready stays 1, flush_req=0, bjp_cnt=1, mispred_cnt=0.
//  2. Not-taken mispredict: pc=0x100, imm=0x40, prdt=0, rslv=1, rv32=1
//     -> mispred strobe at T; flush_req=1 and flush_pc=0x140 at T+1; ready=0 until the cycle after ack.
//  3. Taken mispredict, compressed: pc=0x200, prdt=1, rslv=0, rv32=0 -> flush_pc=0x202.
//     Hold ack low 5 cycles -> flush_req and flush_pc stay stable; a second valid is not accepted.
//  4. Priority and wrap:
//     mret with mepc=0x8000_0000 -> flush_pc=0x8000_0000, mispred_cnt unchanged.
//     fencei at pc=0xFFFF_FFFE, rv32=0 -> flush_pc=0x0000_0000.
//  5. Saturation and reset: CNT_W=4, 20 mispredicts -> both counters stick at 15.
//     Assert rst_n low while in FLUSH -> flush_req=0 immediately; all counters read 0 after release.

Source files
------------

// File: rtl/ex_commit_bjp.sv
// Branch/flush commit stage: detects mispredicts and mret/dret/fence.i,
// holds a registered redirect request toward the IFU until acknowledged,
// and keeps saturating branch / mispredict performance counters.
module ex_commit_bjp #(
  parameter int PC_SIZE = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmt_i_valid,
  output logic               cmt_i_ready,
  input  logic               cmt_i_bjp,
  input  logic               cmt_i_mret,
  input  logic               cmt_i_dret,
  input  logic               cmt_i_fencei,
  input  logic               cmt_i_prdt,
  input  logic               cmt_i_rslv,
  input  logic               cmt_i_rv32,
  input  logic [PC_SIZE-1:0] cmt_i_pc,
  input  logic [PC_SIZE-1:0] cmt_i_imm,
  input  logic [PC_SIZE-1:0] csr_mepc,
  input  logic [PC_SIZE-1:0] csr_dpc,
  output logic               flush_req,
  input  logic               flush_ack,
  output logic [PC_SIZE-1:0] flush_pc,
  output logic               cmt_o_mispred,
  output logic [CNT_W-1:0]   bjp_cnt,
  output logic [CNT_W-1:0]   mispred_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t             state;
  logic               fire;
  logic               mispred;
  logic               need_flush;
  logic [PC_SIZE-1:0] len;
  logic [PC_SIZE-1:0] seq_pc;
  logic [PC_SIZE-1:0] br_pc;
  logic [PC_SIZE-1:0] target;

  // Commit is accepted whenever no redirect is pending, regardless of valid.
  assign cmt_i_ready   = (state == IDLE);
  assign fire          = cmt_i_valid & cmt_i_ready;
  assign mispred       = cmt_i_bjp & (cmt_i_prdt ^ cmt_i_rslv);
  assign need_flush    = mispred | cmt_i_mret | cmt_i_dret | cmt_i_fencei;
  assign cmt_o_mispred = fire & mispred;

  // Instruction length is 4 for 32-bit encodings, 2 for compressed ones.
  assign len    = {{(PC_SIZE-3){1'b0}}, cmt_i_rv32, ~cmt_i_rv32, 1'b0};
  // Adds wrap modulo 2^PC_SIZE; the carry out is simply dropped.
  assign seq_pc = cmt_i_pc + len;
  assign br_pc  = cmt_i_pc + cmt_i_imm;

  // Redirect target selection: dret beats mret beats fence.i beats branch fix-up.
  always_comb begin
    target = seq_pc;
    if (cmt_i_dret) begin
      target = csr_dpc;
    end else if (cmt_i_mret) begin
      target = csr_mepc;
    end else if (cmt_i_fencei) begin
      target = seq_pc;
    end else if (cmt_i_rslv) begin
      target = br_pc;
    end else begin
      target = seq_pc;
    end
  end

  // Flush FSM with registered request and target; target frozen while in FLUSH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      flush_req <= 1'b0;
      flush_pc  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fire && need_flush) begin
            state     <= FLUSH;
            flush_req <= 1'b1;
            flush_pc  <= target;
          end
        end
        FLUSH: begin
          if (flush_ack) begin
            state     <= IDLE;
            flush_req <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          flush_req <= 1'b0;
        end
      endcase
    end
  end

  // Saturating performance counters; both may step in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bjp_cnt     <= '0;
      mispred_cnt <= '0;
    end else begin
      if (fire && cmt_i_bjp && (bjp_cnt != {CNT_W{1'b1}})) begin
        bjp_cnt <= bjp_cnt + CNT_W'(1);
      end
      if (fire && mispred && (mispred_cnt != {CNT_W{1'b1}})) begin
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

endmodule
